// File: rtl/axi4_mem_slave.sv
// AXI4 memory responder for the 64-bit DataMover S2MM/MM2S ports, backed by a byte-strobed RAM.
// Define AXI_MEM_STATS_EN to add beat/error statistics counters and their ports.
module axi4_mem_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_AW    = 12,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk_ps,
    input  logic        rst_n,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
`ifdef AXI_MEM_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] stat_wr_beats,
    output logic [31:0] stat_rd_beats,
    output logic [15:0] stat_err_cnt
`endif
);
    localparam int          DEPTH     = 1 << MEM_AW;
    localparam logic [32:0] MEM_BYTES = 33'd1 << (MEM_AW + 3);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    w_state_t          r_wstate, w_wstate_next;
    logic [31:0]       r_waddr;
    logic [7:0]        r_wlen, r_wcnt;
    logic              r_wslv, r_wdec;
    logic [1:0]        r_bresp;
    logic              w_aw_hs, w_w_hs, w_b_hs;
    logic [31:0]       w_woff;
    logic              w_win, w_wfinal, w_wlast_err, w_we;
    logic [MEM_AW-1:0] w_widx;

    r_state_t          r_rstate, w_rstate_next;
    logic [31:0]       r_raddr;
    logic [7:0]        r_rlen, r_rcnt;
    logic              r_rslv;
    logic [3:0]        r_rwait;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic              w_ar_hs, w_r_hs, w_rload, w_rld_last, w_rin;
    logic [31:0]       w_rld_addr, w_rld_off;
    logic [MEM_AW-1:0] w_ridx;

    assign w_aw_hs     = (r_wstate == W_IDLE) && s_axi_awvalid;
    assign w_w_hs      = (r_wstate == W_DATA) && s_axi_wvalid;
    assign w_b_hs      = (r_wstate == W_RESP) && s_axi_bready;
    assign w_woff      = r_waddr - ADDR_BASE;
    assign w_win       = {1'b0, w_woff} < MEM_BYTES;
    assign w_widx      = w_woff[MEM_AW+2:3];
    assign w_wfinal    = (r_wcnt == r_wlen);
    assign w_wlast_err = (s_axi_wlast != w_wfinal);
    assign w_we        = w_w_hs && w_win;
    assign s_axi_bresp = r_bresp;

    always_comb begin
        w_wstate_next = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (w_aw_hs) w_wstate_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (w_w_hs && w_wfinal) w_wstate_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (w_b_hs) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wslv   <= 1'b0;
            r_wdec   <= 1'b0;
            r_bresp  <= 2'b00;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_aw_hs) begin
                r_waddr <= s_axi_awaddr;
                r_wlen  <= s_axi_awlen;
                r_wcnt  <= '0;
                r_wslv  <= (s_axi_awsize != 3'b011) || (s_axi_awburst != 2'b01);
                r_wdec  <= 1'b0;
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + 32'd8;
                r_wcnt  <= r_wcnt + 8'd1;
                if (!w_win)      r_wdec <= 1'b1;
                if (w_wlast_err) r_wslv <= 1'b1;
                // Final beat folds its own flags in, since r_wdec/r_wslv update at the same edge.
                if (w_wfinal)
                    r_bresp <= (r_wdec || !w_win)        ? 2'b11 :
                               (r_wslv || w_wlast_err)   ? 2'b10 : 2'b00;
            end
        end
    end

    assign w_ar_hs     = (r_rstate == R_IDLE) && s_axi_arvalid;
    assign w_r_hs      = (r_rstate == R_DATA) && s_axi_rready;
    assign w_rld_off   = w_rld_addr - ADDR_BASE;
    assign w_rin       = {1'b0, w_rld_off} < MEM_BYTES;
    assign w_ridx      = w_rld_off[MEM_AW+2:3];
    assign s_axi_rresp = r_rresp;
    assign s_axi_rlast = r_rlast;

    always_comb begin
        w_rstate_next = r_rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        w_rload       = 1'b0;
        w_rld_addr    = r_raddr;
        w_rld_last    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (w_ar_hs) w_rstate_next = R_WAIT;
            end
            R_WAIT: begin
                if (r_rwait == 4'd0) begin
                    w_rstate_next = R_DATA;
                    w_rload       = 1'b1;
                    w_rld_last    = (r_rlen == 8'd0);
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (w_r_hs) begin
                    if (r_rcnt == r_rlen) begin
                        w_rstate_next = R_IDLE;
                    end else begin
                        // Prefetch the next beat on the handshake so R streams without bubbles.
                        w_rload    = 1'b1;
                        w_rld_addr = r_raddr + 32'd8;
                        w_rld_last = ((r_rcnt + 8'd1) == r_rlen);
                    end
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rslv   <= 1'b0;
            r_rwait  <= '0;
            r_rresp  <= 2'b00;
            r_rlast  <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_raddr <= s_axi_araddr;
                r_rlen  <= s_axi_arlen;
                r_rcnt  <= '0;
                r_rslv  <= (s_axi_arsize != 3'b011) || (s_axi_arburst != 2'b01);
                r_rwait <= 4'(RD_LAT - 1);
            end
            if (r_rstate == R_WAIT && r_rwait != 4'd0) r_rwait <= r_rwait - 4'd1;
            if (w_r_hs) begin
                r_raddr <= r_raddr + 32'd8;
                r_rcnt  <= r_rcnt + 8'd1;
                if (r_rcnt == r_rlen) r_rlast <= 1'b0;
            end
            if (w_rload) begin
                r_rlast <= w_rld_last;
                r_rresp <= !w_rin ? 2'b11 : (r_rslv ? 2'b10 : 2'b00);
            end
        end
    end

    // One RAM per byte lane; the read register samples before the same-edge write.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH];
            logic [7:0] r_rbyte;

            always_ff @(posedge clk_ps) begin
                if (w_we && s_axi_wstrb[gi]) r_lane[w_widx] <= s_axi_wdata[8*gi +: 8];
            end

            always_ff @(posedge clk_ps or negedge rst_n) begin
                if (!rst_n)       r_rbyte <= '0;
                else if (w_rload) r_rbyte <= w_rin ? r_lane[w_ridx] : 8'd0;
            end

            assign s_axi_rdata[8*gi +: 8] = r_rbyte;
        end
    endgenerate

`ifdef AXI_MEM_STATS_EN
    logic [31:0] r_stat_wr, r_stat_rd;
    logic [15:0] r_stat_err;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = 2'(w_b_hs && (r_bresp != 2'b00)) + 2'(w_r_hs && (r_rresp != 2'b00));
    assign w_err_sum = {1'b0, r_stat_err} + {15'd0, w_err_inc};

    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_err <= '0;
        end else if (stats_clr) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_err <= '0;
        end else begin
            if (w_w_hs && r_stat_wr != '1) r_stat_wr <= r_stat_wr + 32'd1;
            if (w_r_hs && r_stat_rd != '1) r_stat_rd <= r_stat_rd + 32'd1;
            r_stat_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign stat_wr_beats = r_stat_wr;
    assign stat_rd_beats = r_stat_rd;
    assign stat_err_cnt  = r_stat_err;
`endif
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed scoreboard bench for axi4_mem_slave: bench-side memory model predicts B and R responses.
`timescale 1ns/1ps
module tb_axi4_mem_slave;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          AW   = 12;
    localparam int          LAT  = 2;
    localparam logic [31:0] SPAN = 32'd1 << (AW + 3);
    localparam logic [31:0] TOP  = BASE + SPAN;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'b011;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata = '0;
    logic [7:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'b011;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
`ifdef AXI_MEM_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] stat_wr_beats, stat_rd_beats;
    logic [15:0] stat_err_cnt;
`endif

    axi4_mem_slave #(.ADDR_BASE(BASE), .MEM_AW(AW), .RD_LAT(LAT)) dut (
        .clk_ps(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
`ifdef AXI_MEM_STATS_EN
        ,
        .stats_clr(stats_clr), .stat_wr_beats(stat_wr_beats),
        .stat_rd_beats(stat_rd_beats), .stat_err_cnt(stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] mdl [int unsigned];
    logic [63:0] wbuf [256];
    rbeat_t      r_q [$];
    logic [1:0]  b_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < SPAN;
    endfunction

    function automatic void mdl_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int unsigned w;
        logic [63:0] v;
        w = (a - BASE) >> 3;
        v = mdl.exists(w) ? mdl[w] : 64'd0;
        for (int i = 0; i < 8; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        mdl[w] = v;
    endfunction

    function automatic logic [63:0] mdl_read(input logic [31:0] a);
        int unsigned w;
        w = (a - BASE) >> 3;
        return mdl.exists(w) ? mdl[w] : 64'd0;
    endfunction

    // last_beat: beat carrying wlast (-1 = never); bhold: cycles bready is withheld.
    task automatic axi_write(input string tag, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                             input int last_beat, input int bhold);
        int          wc;
        bit          dec, slv;
        logic [31:0] a;
        logic [1:0]  exp;
        dec = 1'b0;
        slv = (size != 3'b011) || (burst != 2'b01) || (last_beat != len);
        for (int b = 0; b <= len; b++) if (!in_rng(addr + 32'(8 * b))) dec = 1'b1;
        b_q.push_back(dec ? 2'b11 : (slv ? 2'b10 : 2'b00));

        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        wc = 0;
        while (s_axi_awready !== 1'b1 && wc < 50) begin tick(); wc++; end
        if (wc >= 50) begin timeout({tag, "_aw"}); s_axi_awvalid = 1'b0; return; end
        tick();
        s_axi_awvalid = 1'b0;

        for (int b = 0; b <= len; b++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[b]; s_axi_wstrb = strb;
            s_axi_wlast = (b == last_beat);
            wc = 0;
            while (s_axi_wready !== 1'b1 && wc < 50) begin tick(); wc++; end
            if (wc >= 50) begin timeout({tag, "_w"}); s_axi_wvalid = 1'b0; return; end
            a = addr + 32'(8 * b);
            if (in_rng(a)) mdl_write(a, wbuf[b], strb);
            tick();
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;

        check({tag, "_bvalid_next"}, 64'(s_axi_bvalid), 64'd1);
        wc = 0;
        while (s_axi_bvalid !== 1'b1 && wc < 50) begin tick(); wc++; end
        if (wc >= 50) begin timeout({tag, "_b"}); return; end
        for (int i = 0; i < bhold; i++) begin
            check({tag, "_bhold_bvalid"}, 64'(s_axi_bvalid), 64'd1);
            check({tag, "_bhold_awready"}, 64'(s_axi_awready), 64'd0);
            tick();
        end
        exp = b_q.pop_front();
        check({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp));
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check({tag, "_bvalid_clr"}, 64'(s_axi_bvalid), 64'd0);
        check({tag, "_awready_back"}, 64'(s_axi_awready), 64'd1);
        $display("WR %s addr=%08h len=%0d bresp=%0d", tag, addr, len, exp);
    endtask

    // mode 0: rready always high; mode 1: rready pattern 1,0,0 repeating. stop_after<0 runs the whole burst.
    task automatic axi_read(input string tag, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int mode, input int stop_after);
        int          wc, hs, cyc, lat;
        bit          slv;
        rbeat_t      e;
        logic [31:0] a;
        slv = (size != 3'b011) || (burst != 2'b01);
        for (int b = 0; b <= len; b++) begin
            a = addr + 32'(8 * b);
            e.data = in_rng(a) ? mdl_read(a) : 64'd0;
            e.resp = !in_rng(a) ? 2'b11 : (slv ? 2'b10 : 2'b00);
            e.last = (b == len);
            r_q.push_back(e);
        end

        s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        wc = 0;
        while (s_axi_arready !== 1'b1 && wc < 50) begin tick(); wc++; end
        if (wc >= 50) begin timeout({tag, "_ar"}); s_axi_arvalid = 1'b0; return; end
        tick();
        s_axi_arvalid = 1'b0;

        lat = 0;
        while (s_axi_rvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        if (lat >= 50) begin timeout({tag, "_rvalid"}); r_q.delete(); return; end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));

        hs = 0; cyc = 0;
        while (hs < len + 1 && hs != stop_after && cyc < 2000) begin
            s_axi_rready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            check({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd1);
            if (s_axi_rvalid === 1'b1 && r_q.size() > 0) begin
                e = r_q[0];
                check({tag, "_rdata"}, s_axi_rdata, e.data);
                check({tag, "_rresp"}, 64'(s_axi_rresp), 64'(e.resp));
                check({tag, "_rlast"}, 64'(s_axi_rlast), 64'(e.last));
                if (s_axi_rready) begin
                    void'(r_q.pop_front());
                    hs++;
                end
            end
            tick();
            cyc++;
        end
        s_axi_rready = 1'b0;
        if (cyc >= 2000) timeout({tag, "_rbeats"});
        if (stop_after < 0) begin
            check({tag, "_handshakes"}, 64'(hs), 64'(len + 1));
            check({tag, "_rvalid_end"}, 64'(s_axi_rvalid), 64'd0);
            check({tag, "_arready_back"}, 64'(s_axi_arready), 64'd1);
        end
        $display("RD %s addr=%08h len=%0d beats=%0d", tag, addr, len, hs);
    endtask

    initial begin
        #3;
        check("rst_awready", 64'(s_axi_awready), 64'd1);
        check("rst_arready", 64'(s_axi_arready), 64'd1);
        check("rst_wready",  64'(s_axi_wready),  64'd0);
        check("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
        check("rst_bresp",   64'(s_axi_bresp),   64'd0);
        check("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("rst_rlast",   64'(s_axi_rlast),   64'd0);
        check("rst_rresp",   64'(s_axi_rresp),   64'd0);
        check("rst_rdata",   s_axi_rdata,        64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();

        wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
        wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
        axi_write("basic", BASE + 32'h40, 3, 3'b011, 2'b01, 8'hFF, 3, 0);
        axi_read("basic", BASE + 32'h40, 3, 3'b011, 2'b01, 0, -1);

        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write("strb_full", BASE + 32'h100, 0, 3'b011, 2'b01, 8'hFF, 0, 0);
        wbuf[0] = 64'h0;
        axi_write("strb_low", BASE + 32'h100, 0, 3'b011, 2'b01, 8'h0F, 0, 0);
        check("strb_model", mdl_read(BASE + 32'h100), 64'hFFFF_FFFF_0000_0000);
        axi_read("strb", BASE + 32'h100, 0, 3'b011, 2'b01, 0, -1);

        for (int i = 0; i < 8; i++) wbuf[i] = {8{8'(8'h10 + i)}} ^ 64'hA5A5_0000_0000_5A5A;
        axi_write("long", BASE + 32'h200, 7, 3'b011, 2'b01, 8'hFF, 7, 0);
        axi_read("stall", BASE + 32'h200, 7, 3'b011, 2'b01, 1, -1);

        wbuf[0] = 64'hDEAD_BEEF_0000_0001; wbuf[1] = 64'hDEAD_BEEF_0000_0002;
        axi_write("badsize", BASE + 32'h300, 1, 3'b010, 2'b01, 8'hFF, 1, 0);
        axi_read("badsize_ok", BASE + 32'h300, 1, 3'b011, 2'b01, 0, -1);
        axi_read("badburst", BASE + 32'h300, 1, 3'b011, 2'b10, 0, -1);
        axi_read("oob", TOP, 0, 3'b011, 2'b01, 0, -1);
        wbuf[0] = 64'hCAFE_0000_0000_0001; wbuf[1] = 64'hCAFE_0000_0000_0002;
        axi_write("straddle", TOP - 32'd8, 1, 3'b011, 2'b01, 8'hFF, 1, 0);
        axi_read("straddle", TOP - 32'd8, 1, 3'b011, 2'b01, 0, -1);
        axi_read("wrap", 32'hFFFF_FFF8, 1, 3'b011, 2'b01, 0, -1);

        wbuf[0] = 64'h1; wbuf[1] = 64'h2; wbuf[2] = 64'h3;
        axi_write("nolast", BASE + 32'h400, 2, 3'b011, 2'b01, 8'hFF, -1, 0);
        axi_write("earlylast", BASE + 32'h400, 2, 3'b011, 2'b01, 8'hFF, 0, 0);
        axi_read("lasterr_data", BASE + 32'h400, 2, 3'b011, 2'b01, 0, -1);

        wbuf[0] = 64'h0123_4567_89AB_CDEF;
        axi_write("bhold", BASE + 32'h500, 0, 3'b011, 2'b01, 8'hFF, 0, 20);

        axi_read("midrst", BASE + 32'h200, 7, 3'b011, 2'b01, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("midrst_arready", 64'(s_axi_arready), 64'd1);
        check("midrst_rlast",   64'(s_axi_rlast),   64'd0);
        r_q.delete();
        $display("RST asserted mid-read, queue flushed");
        @(negedge clk); rst_n = 1'b1;
        tick();
        axi_read("after_rst", BASE + 32'h40, 3, 3'b011, 2'b01, 0, -1);

`ifdef AXI_MEM_STATS_EN
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        for (int i = 0; i < 256; i++) wbuf[i] = 64'(i) * 64'h0001_0001_0001_0001;
        axi_write("stats_wr", BASE, 255, 3'b011, 2'b01, 8'hFF, 255, 0);
        axi_read("stats_rd", TOP, 0, 3'b011, 2'b01, 0, -1);
        check("stat_wr_beats", 64'(stat_wr_beats), 64'd256);
        check("stat_rd_beats", 64'(stat_rd_beats), 64'd1);
        check("stat_err_cnt",  64'(stat_err_cnt),  64'd1);
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        check("stat_wr_clr",  64'(stat_wr_beats), 64'd0);
        check("stat_rd_clr",  64'(stat_rd_beats), 64'd0);
        check("stat_err_clr", 64'(stat_err_cnt),  64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
